// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Register width for a counter holding 0..n-1; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle divider: pulses step on every PRESCALE-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = clog2_min1(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_s;

  // With PRESCALE=1 the phase is pinned at 0, so step reduces to en.
  assign last_s = (cnt_q == LAST);
  assign step   = en & ~clr & last_s;

  // Next phase: clear on load, freeze while disabled, wrap after the last phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (last_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo up/down counter with load, prescaler, wrap/saturate
// mode, registered terminal-count pulse and sticky overflow.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = (1 << WIDTH) - 1,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam bit               SAT   = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH-1:0] value_q, value_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_s;
  logic             wrap_s;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .step  (step_s)
  );

  assign at_max  = (value_q == MAX_V);
  assign at_zero = (value_q == {WIDTH{1'b0}});
  assign value   = value_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;

  // Next-state mux: load beats a step; bounds are tested before any +/-1.
  always_comb begin
    value_d = value_q;
    tc_d    = 1'b0;
    wrap_s  = 1'b0;
    if (load) begin
      if (load_val > MAX_V) begin
        value_d = MAX_V;
      end else begin
        value_d = load_val;
      end
    end else if (step_s) begin
      if (up) begin
        if (at_max) begin
          tc_d    = 1'b1;
          wrap_s  = ~SAT;
          value_d = SAT ? MAX_V : {WIDTH{1'b0}};
        end else begin
          value_d = value_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          tc_d    = 1'b1;
          wrap_s  = ~SAT;
          value_d = SAT ? {WIDTH{1'b0}} : MAX_V;
        end else begin
          value_d = value_q - WIDTH'(1);
        end
      end
    end else begin
      value_d = value_q;
    end

    // A wrap in the same cycle as clr_ovf keeps the flag set.
    if (wrap_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Count, pulse and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
